usb_rx_packet: RTL and testbench

Receive-side USB full-speed packet decoder between the bit-level receiver (NRZI decode, bit unstuff, byte assembly) and the transaction layer. It takes an SOP/byte/EOP stream, checks the PID and verifies CRC5 or CRC16. It emits the rx_packet_* interface that the transaction layer consumes: PID, 11-bit token address field, payload bytes with CRC stripped, and an end-of-packet fin/valid pair.

---
 rtl/usb_rx_packet.sv | 203 ++++++++++++++++++++
 tb/tb_usb_rx_packet.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet.sv
// usb_rx_packet: USB full-speed receive packet decoder.
// Checks PID, verifies CRC5/CRC16, strips CRC from payload.
module usb_rx_packet #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_sop,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_en,
  input  logic        rx_eop,
  output logic [3:0]  rx_packet_pid,
  output logic        rx_packet_pid_valid,
  output logic [10:0] rx_packet_addr,
  output logic [7:0]  rx_packet_byte,
  output logic        rx_packet_byte_en,
  output logic        rx_packet_valid,
  output logic        rx_packet_fin
);

  localparam int CW = $clog2(MAX_PAYLOAD + 4);
  localparam logic [CW-1:0] CNT_OVF = CW'(MAX_PAYLOAD + 2);

  typedef enum logic [2:0] {
    IDLE, PID, TOKEN, DATA, HSK, DISCARD, DONE
  } state_t;

  state_t state, state_n, st_b;

  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    crc5, crc5_n;
  logic [15:0]   crc16, crc16_n;
  logic [7:0]    dly0, dly0_n;
  logic [7:0]    dly1, dly1_n;
  logic [7:0]    tok_lo, tok_lo_n;
  logic [2:0]    tok_hi, tok_hi_n;

  logic [3:0]    pid_n;
  logic          pid_valid_n;
  logic [10:0]   addr_n;
  logic [7:0]    byte_n;
  logic          byte_en_n;
  logic          valid_n;
  logic          fin_n;
  logic          pkt_good;
  logic          busy;

  function automatic logic [4:0] crc5_step(
    input logic [4:0] c,
    input logic [7:0] d
  );
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[4]) r = {r[3:0], 1'b0} ^ 5'b00101;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_step(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      crc5                <= '0;
      crc16               <= '0;
      dly0                <= '0;
      dly1                <= '0;
      tok_lo              <= '0;
      tok_hi              <= '0;
      rx_packet_pid       <= '0;
      rx_packet_pid_valid <= 1'b0;
      rx_packet_addr      <= '0;
      rx_packet_byte      <= '0;
      rx_packet_byte_en   <= 1'b0;
      rx_packet_valid     <= 1'b0;
      rx_packet_fin       <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      crc5                <= crc5_n;
      crc16               <= crc16_n;
      dly0                <= dly0_n;
      dly1                <= dly1_n;
      tok_lo              <= tok_lo_n;
      tok_hi              <= tok_hi_n;
      rx_packet_pid       <= pid_n;
      rx_packet_pid_valid <= pid_valid_n;
      rx_packet_addr      <= addr_n;
      rx_packet_byte      <= byte_n;
      rx_packet_byte_en   <= byte_en_n;
      rx_packet_valid     <= valid_n;
      rx_packet_fin       <= fin_n;
    end
  end

  assign busy = (state != IDLE) && (state != DONE);

  always_comb begin
    state_n     = state;
    st_b        = state;
    cnt_n       = cnt;
    crc5_n      = crc5;
    crc16_n     = crc16;
    dly0_n      = dly0;
    dly1_n      = dly1;
    tok_lo_n    = tok_lo;
    tok_hi_n    = tok_hi;
    pid_n       = rx_packet_pid;
    pid_valid_n = 1'b0;
    addr_n      = rx_packet_addr;
    byte_n      = rx_packet_byte;
    byte_en_n   = 1'b0;
    valid_n     = 1'b0;
    fin_n       = 1'b0;
    pkt_good    = 1'b0;

    if (rx_sop) begin
      fin_n   = busy;
      state_n = PID;
      cnt_n   = '0;
      crc5_n  = '1;
      crc16_n = '1;
    end else begin
      if (state == DONE) st_b = IDLE;
      if (rx_byte_en) begin
        unique case (state)
          PID: begin
            if (rx_byte[7:4] == ~rx_byte[3:0]) begin
              pid_n       = rx_byte[3:0];
              pid_valid_n = 1'b1;
              unique case (rx_byte[3:0])
                4'b0001, 4'b1001, 4'b1101,
                4'b0101, 4'b0100: st_b = TOKEN;
                4'b0011, 4'b1011,
                4'b0111, 4'b1111: st_b = DATA;
                4'b0010, 4'b1010,
                4'b1110, 4'b0110: st_b = HSK;
                default:          st_b = DISCARD;
              endcase
            end else begin
              st_b = DISCARD;
            end
          end
          TOKEN: begin
            crc5_n = crc5_step(crc5, rx_byte);
            cnt_n  = cnt + 1'b1;
            if (cnt == CW'(0))      tok_lo_n = rx_byte;
            else if (cnt == CW'(1)) tok_hi_n = rx_byte[2:0];
            else                    st_b = DISCARD;
          end
          DATA: begin
            crc16_n = crc16_step(crc16, rx_byte);
            // Oldest byte leaves the delay line once two newer ones exist
            if (cnt == CNT_OVF) begin
              st_b = DISCARD;
            end else begin
              cnt_n  = cnt + 1'b1;
              dly0_n = dly1;
              dly1_n = rx_byte;
              if (cnt >= CW'(2)) begin
                byte_n    = dly0;
                byte_en_n = 1'b1;
              end
            end
          end
          HSK:     st_b = DISCARD;
          default: ;
        endcase
      end

      state_n = st_b;
      if (rx_eop && busy) begin
        unique case (st_b)
          TOKEN: pkt_good = (cnt_n == CW'(2)) &&
                            (crc5_n == 5'b01100);
          DATA:  pkt_good = (cnt_n >= CW'(2)) &&
                            (crc16_n == 16'h800D);
          HSK:   pkt_good = 1'b1;
          default: pkt_good = 1'b0;
        endcase
        state_n = DONE;
        fin_n   = 1'b1;
        valid_n = pkt_good;
        if (pkt_good && st_b == TOKEN) addr_n = {tok_hi_n, tok_lo_n};
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_packet.sv
// tb_usb_rx_packet: directed + random packets vs
// a byte-level reference model of the decoder.
module tb_usb_rx_packet;

  localparam int MAXP = 64;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst;
  logic        rx_sop;
  logic [7:0]  rx_byte;
  logic        rx_byte_en;
  logic        rx_eop;
  logic [3:0]  rx_packet_pid;
  logic        rx_packet_pid_valid;
  logic [10:0] rx_packet_addr;
  logic [7:0]  rx_packet_byte;
  logic        rx_packet_byte_en;
  logic        rx_packet_valid;
  logic        rx_packet_fin;

  usb_rx_packet #(.MAX_PAYLOAD(MAXP)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_sop              (rx_sop),
    .rx_byte             (rx_byte),
    .rx_byte_en          (rx_byte_en),
    .rx_eop              (rx_eop),
    .rx_packet_pid       (rx_packet_pid),
    .rx_packet_pid_valid (rx_packet_pid_valid),
    .rx_packet_addr      (rx_packet_addr),
    .rx_packet_byte      (rx_packet_byte),
    .rx_packet_byte_en   (rx_packet_byte_en),
    .rx_packet_valid     (rx_packet_valid),
    .rx_packet_fin       (rx_packet_fin)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int         n_pidv;
  int         n_stray;
  logic [3:0] mon_pid;
  bq_t        got_q;
  logic       fin_q[$];
  logic [10:0] m_addr;

  logic [7:0] tok_pids[5] = '{8'hE1, 8'h69, 8'h2D, 8'hA5, 8'hB4};
  logic [7:0] dat_pids[4] = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
  logic [7:0] hsk_pids[4] = '{8'hD2, 8'h5A, 8'h1E, 8'h96};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (rx_packet_pid_valid) begin
      n_pidv++;
      mon_pid = rx_packet_pid;
    end
    if (rx_packet_byte_en) got_q.push_back(rx_packet_byte);
    if (rx_packet_fin) fin_q.push_back(rx_packet_valid);
    if (rx_packet_valid && !rx_packet_fin) n_stray++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [4:0] tok_crc(input logic [10:0] f);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++)
      c = (c[0] ^ f[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    return ~c;
  endfunction

  // Reflected CRC-16/USB over p[1..n]
  function automatic logic [15:0] dat_crc(input bq_t p, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 1; i <= n; i++) begin
      c = c ^ {8'h00, p[i]};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic model(input bq_t p,
                       output int pv,
                       output logic [3:0] pd,
                       output bq_t eb,
                       output logic v);
    int rest;
    int pay;
    logic [10:0] f;
    pv = 0;
    pd = '0;
    eb = {};
    v  = 1'b0;
    if (p.size() == 0) return;
    if (p[0][7:4] != ~p[0][3:0]) return;
    pv   = 1;
    pd   = p[0][3:0];
    rest = p.size() - 1;
    case (p[0][3:0])
      4'h1, 4'h9, 4'hD, 4'h5, 4'h4: begin
        if (rest == 2) begin
          f = {p[2][2:0], p[1]};
          v = (tok_crc(f) == p[2][7:3]);
          if (v) m_addr = f;
        end
      end
      4'h3, 4'hB, 4'h7, 4'hF: begin
        pay = rest - 2;
        for (int i = 1; i <= pay && i <= MAXP; i++)
          eb.push_back(p[i]);
        if (rest >= 2 && pay <= MAXP)
          v = (dat_crc(p, pay) == {p[rest], p[rest-1]});
      end
      4'h2, 4'hA, 4'hE, 4'h6: v = (rest == 0);
      default: ;
    endcase
  endtask

  task automatic cyc(input logic s, input logic e,
                     input logic [7:0] b, input logic p);
    rx_sop     = s;
    rx_byte_en = e;
    rx_byte    = b;
    rx_eop     = p;
    @(posedge clk);
    #1;
    rx_sop     = 1'b0;
    rx_byte_en = 1'b0;
    rx_eop     = 1'b0;
  endtask

  task automatic mon_clear();
    n_pidv = 0;
    got_q.delete();
    fin_q.delete();
  endtask

  task automatic send(input bq_t p, input bit eop_last);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < p.size(); i++)
      cyc(1'b0, 1'b1, p[i], eop_last && (i == p.size() - 1));
    if (!eop_last || p.size() == 0) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic run_pkt(input bq_t p, input bit eop_last,
                         input string tag);
    int         e_pv;
    logic [3:0] e_pd;
    bq_t        e_b;
    logic       e_v;
    mon_clear();
    send(p, eop_last);
    model(p, e_pv, e_pd, e_b, e_v);
    chk({tag, ".pidv"}, 32'(n_pidv), 32'(e_pv));
    if (e_pv != 0) chk({tag, ".pid"}, 32'(mon_pid), 32'(e_pd));
    chk({tag, ".nbyte"}, 32'(got_q.size()), 32'(e_b.size()));
    for (int i = 0; i < e_b.size() && i < got_q.size(); i++)
      chk({tag, ".byte"}, 32'(got_q[i]), 32'(e_b[i]));
    chk({tag, ".nfin"}, 32'(fin_q.size()), 32'd1);
    if (fin_q.size() != 0)
      chk({tag, ".valid"}, 32'(fin_q[0]), 32'(e_v));
    chk({tag, ".addr"}, 32'(rx_packet_addr), 32'(m_addr));
  endtask

  function automatic bq_t mk_data(input logic [7:0] pid, input int n);
    bq_t p;
    logic [15:0] c;
    p = {pid};
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    c = dat_crc(p, n);
    p.push_back(c[7:0]);
    p.push_back(c[15:8]);
    return p;
  endfunction

  task automatic gen(output bq_t p);
    int k;
    int n;
    int ix;
    logic [10:0] f;
    logic [7:0]  b;
    k = $urandom_range(0, 4);
    p = {};
    case (k)
      0: begin
        f = 11'($urandom);
        p = {tok_pids[$urandom_range(0, 4)], f[7:0],
             {tok_crc(f), f[10:8]}};
        if ($urandom_range(0, 3) == 0) begin
          ix = $urandom_range(1, 2);
          p[ix] = p[ix] ^ 8'(1 << $urandom_range(0, 7));
        end
        if ($urandom_range(0, 5) == 0) p.push_back(8'($urandom));
      end
      1, 2: begin
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 68)
                                        : $urandom_range(0, 12);
        p = mk_data(dat_pids[$urandom_range(0, 3)], n);
        if ($urandom_range(0, 3) == 0) begin
          ix = $urandom_range(1, p.size() - 1);
          p[ix] = p[ix] ^ 8'(1 << $urandom_range(0, 7));
        end
        if ($urandom_range(0, 7) == 0)
          while (p.size() > 2) void'(p.pop_back());
      end
      3: begin
        p = {hsk_pids[$urandom_range(0, 3)]};
        if ($urandom_range(0, 3) == 0) p.push_back(8'($urandom));
      end
      default: begin
        b = 8'($urandom);
        if (b[7:4] == ~b[3:0]) b[7] = ~b[7];
        p = {b};
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      end
    endcase
  endtask

  initial begin
    bq_t p;
    n_stray    = 0;
    m_addr     = '0;
    rst        = 1'b1;
    rx_sop     = 1'b0;
    rx_byte    = '0;
    rx_byte_en = 1'b0;
    rx_eop     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'({rx_packet_pid, rx_packet_pid_valid,
        rx_packet_addr, rx_packet_byte, rx_packet_byte_en,
        rx_packet_valid, rx_packet_fin}), 32'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    run_pkt('{8'hD2}, 1'b0, "ack");
    run_pkt('{8'h2D, 8'h00, 8'h10}, 1'b0, "setup");
    run_pkt('{8'h2D, 8'h00, 8'h11}, 1'b1, "setup_bad");
    run_pkt('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00,
              8'h40, 8'h00, 8'hDD, 8'h94}, 1'b0, "getdesc");
    run_pkt('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00,
              8'h40, 8'h00, 8'hDD, 8'h95}, 1'b1, "getdesc_bad");
    run_pkt('{8'h4B, 8'h00, 8'h00}, 1'b0, "zlp");
    run_pkt('{8'h4B, 8'h00}, 1'b0, "zlp_short");
    run_pkt('{8'h2E, 8'h12, 8'h34}, 1'b0, "badpid");
    run_pkt('{}, 1'b0, "nopid");
    run_pkt('{8'hD2, 8'h00}, 1'b1, "ack_extra");
    run_pkt(mk_data(8'h87, MAXP), 1'b0, "max");
    run_pkt(mk_data(8'hC3, MAXP + 1), 1'b1, "ovf");

    // Abort a DATA packet with a new SOP, then an ACK
    mon_clear();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hC3, 1'b0);
    cyc(1'b0, 1'b1, 8'h11, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 1'b0);
    cyc(1'b0, 1'b1, 8'h33, 1'b0);
    cyc(1'b0, 1'b1, 8'h44, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hD2, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("abort.nfin", 32'(fin_q.size()), 32'd2);
    if (fin_q.size() == 2) begin
      chk("abort.v0", 32'(fin_q[0]), 32'd0);
      chk("abort.v1", 32'(fin_q[1]), 32'd1);
    end
    chk("abort.nbyte", 32'(got_q.size()), 32'd2);
    chk("abort.pid", 32'(mon_pid), 32'h2);

    for (int t = 0; t < 60; t++) begin
      gen(p);
      run_pkt(p, 1'($urandom_range(0, 1)), "rnd");
    end

    // Reset in the middle of a DATA packet
    mon_clear();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hC3, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_addr = '0;
    chk("rst_mid", 32'({rx_packet_pid, rx_packet_pid_valid,
        rx_packet_addr, rx_packet_byte, rx_packet_byte_en,
        rx_packet_valid, rx_packet_fin}), 32'd0);
    cyc(1'b0, 1'b1, 8'h55, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_mid.nfin", 32'(fin_q.size()), 32'd0);
    run_pkt('{8'h5A}, 1'b0, "nak_after_rst");

    chk("stray_valid", 32'(n_stray), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
